avl_ram_slave: RTL and testbench



---
 rtl/avl_ram_slave_pkg.sv | 13 +
 rtl/avl_ram_slave_if.sv | 31 +++
 rtl/avl_ram_slave_bytewise.sv | 40 ++++
 rtl/avl_ram_slave.sv | 125 ++++++++++++
 tb/tb_avl_ram_slave.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/avl_ram_slave_pkg.sv
// Shared types and constants for the Avalon RAM responder.
package avl_pkg;

    localparam int unsigned AVL_DATA_W = 32;
    localparam int unsigned AVL_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } avl_slave_state_e;

endpackage

// File: rtl/avl_ram_slave_if.sv
// Avalon-MM data bus between the core's memory stage (master) and a RAM responder (slave).
interface avl_ram_slave_if
    import avl_pkg::*;
#(
    parameter int unsigned BURST_WIDTH = 8
);

    logic [31:0]             address;
    logic [AVL_BE_W-1:0]     byte_en;
    logic                    read;
    logic                    write;
    logic [AVL_DATA_W-1:0]   write_data;
    logic                    begin_burst_transfer;
    logic [BURST_WIDTH-1:0]  burst_count;
    logic                    request_ready;
    logic [AVL_DATA_W-1:0]   read_data;
    logic                    read_data_valid;

    modport master (
        output address, byte_en, read, write, write_data,
               begin_burst_transfer, burst_count,
        input  request_ready, read_data, read_data_valid
    );

    modport slave (
        input  address, byte_en, read, write, write_data,
               begin_burst_transfer, burst_count,
        output request_ready, read_data, read_data_valid
    );

endinterface

// File: rtl/avl_ram_slave_bytewise.sv
// Single-port word RAM with byte-lane write enables and a registered read port.
// The array itself is never reset; only the read output register is.
module avl_ram_bytewise
  import avl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter              INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AVL_BE_W-1:0]   be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [AVL_DATA_W-1:0] wdata,
  input  logic                  re,
  output logic [AVL_DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [AVL_DATA_W-1:0] mem [DEPTH];
  logic [AVL_DATA_W-1:0] wmask;

  assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/avl_ram_slave.sv
// Avalon-MM RAM responder: single beats and incrementing bursts, one-cycle read latency.
module avl_ram_slave
    import avl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned BURST_WIDTH = 8,
    parameter              INIT_FILE   = ""
) (
    input  logic          clk,
    input  logic          rest,
    avl_ram_slave_if.slave avl_s0
);

    avl_slave_state_e        state, state_nxt;
    logic [ADDR_WIDTH-1:0]   req_word;
    logic [ADDR_WIDTH-1:0]   burst_addr, burst_addr_nxt;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [BURST_WIDTH-1:0]  beat_cnt, beat_cnt_nxt;
    logic                    ram_we;
    logic                    ram_re;
    logic                    is_burst;
    logic                    last_beat;
    logic                    rd_valid;
    logic                    unused_addr_bits;

    assign req_word         = avl_s0.address[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{avl_s0.address[31:ADDR_WIDTH+2], avl_s0.address[1:0]};
    assign is_burst         = avl_s0.begin_burst_transfer &&
                              (avl_s0.burst_count >= BURST_WIDTH'(2));
    assign last_beat        = (beat_cnt == BURST_WIDTH'(1));

    assign avl_s0.request_ready   = (state != RD_BURST);
    assign avl_s0.read_data_valid = rd_valid;

    // Next-state, RAM port steering and burst address/counter update.
    // The first beat of a burst is served from the request address in IDLE,
    // so the register is loaded with the following word and L-1 beats remain.
    always_comb begin
        state_nxt      = state;
        burst_addr_nxt = burst_addr;
        beat_cnt_nxt   = beat_cnt;
        ram_addr       = req_word;
        ram_we         = 1'b0;
        ram_re         = 1'b0;
        case (state)
            IDLE: begin
                if (avl_s0.write) begin
                    ram_we = 1'b1;
                    if (is_burst) begin
                        state_nxt      = WR_BURST;
                        burst_addr_nxt = req_word + ADDR_WIDTH'(1);
                        beat_cnt_nxt   = avl_s0.burst_count - BURST_WIDTH'(1);
                    end
                end else if (avl_s0.read) begin
                    ram_re = 1'b1;
                    if (is_burst) begin
                        state_nxt      = RD_BURST;
                        burst_addr_nxt = req_word + ADDR_WIDTH'(1);
                        beat_cnt_nxt   = avl_s0.burst_count - BURST_WIDTH'(1);
                    end
                end
            end
            RD_BURST: begin
                ram_addr       = burst_addr;
                ram_re         = 1'b1;
                burst_addr_nxt = burst_addr + ADDR_WIDTH'(1);
                beat_cnt_nxt   = beat_cnt - BURST_WIDTH'(1);
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            WR_BURST: begin
                ram_addr = burst_addr;
                if (avl_s0.write) begin
                    ram_we         = 1'b1;
                    burst_addr_nxt = burst_addr + ADDR_WIDTH'(1);
                    beat_cnt_nxt   = beat_cnt - BURST_WIDTH'(1);
                    if (last_beat) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, burst address and beat counter registers.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state      <= IDLE;
            burst_addr <= '0;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            burst_addr <= burst_addr_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    // Read-valid follows the RAM read strobe by one cycle.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= ram_re;
        end
    end

    avl_ram_bytewise #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .rst_n (rest),
        .we    (ram_we),
        .be    (avl_s0.byte_en),
        .addr  (ram_addr),
        .wdata (avl_s0.write_data),
        .re    (ram_re),
        .rdata (avl_s0.read_data)
    );

endmodule

// File: tb/tb_avl_ram_slave.sv
// Directed testbench for avl_ram_slave: single-beat vector table plus burst/reset sequences.
module tb_avl_ram_slave;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_v;
        logic        chk_d;
        logic [31:0] exp_d;
    } vec_t;

    logic clk = 1'b0;
    logic rest;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [14];

    always #5 clk = ~clk;

    avl_ram_slave_if #(.BURST_WIDTH(8)) bus ();

    avl_ram_slave #(
        .ADDR_WIDTH  (10),
        .BURST_WIDTH (8),
        .INIT_FILE   ("")
    ) dut (
        .clk    (clk),
        .rest   (rest),
        .avl_s0 (bus)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input logic bb, input logic [7:0] cnt);
        bus.read                 = rd;
        bus.write                = wr;
        bus.address              = a;
        bus.write_data           = d;
        bus.byte_en              = be;
        bus.begin_burst_transfer = bb;
        bus.burst_count          = cnt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 8'd0);
    endtask

    task automatic single_write(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b1, a, d, 4'hF, 1'b0, 8'd0);
        cyc();
        idle();
    endtask

    task automatic single_read(input string nm, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0, 8'd0);
        cyc();
        idle();
        check({nm, " valid"}, 32'(bus.read_data_valid), 32'd1);
        check({nm, " data"}, bus.read_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rd    wr    addr          wdata         be    v     chk   data
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 1'b1, 32'h12BB_56DD};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h0000_0011, 4'h8, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         4'h0, 1'b1, 1'b1, 32'h00FE_F00D};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 1'b1, 32'h12BB_56DD};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 1'b1, 32'h12BB_56DD};
        vecs[8]  = '{1'b0, 1'b1, 32'h1000_1018, 32'h1111_1111, 4'hF, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0018, 32'h2222_2222, 4'h0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'hFFFF_F01B, 32'h0,         4'h0, 1'b1, 1'b1, 32'h1111_1111};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF};

        // Reset
        idle();
        rest = 1'b1;
        #2 rest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(bus.request_ready), 32'd1);
        check("reset valid", 32'(bus.read_data_valid), 32'd0);
        check("reset data", bus.read_data, 32'h0);
        rest = 1'b1;
        cyc();

        // Single-beat vector table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0, 8'd0);
            cyc();
            check($sformatf("vec%0d valid", i), 32'(bus.read_data_valid), 32'(vecs[i].exp_v));
            check($sformatf("vec%0d ready", i), 32'(bus.request_ready), 32'd1);
            if (vecs[i].chk_d) begin
                check($sformatf("vec%0d data", i), bus.read_data, vecs[i].exp_d);
            end
        end
        idle();
        cyc();

        // Read burst of 4 at 0x40, followed by a single read issued on the last data cycle
        for (int w = 0; w < 4; w++) begin
            single_write(32'h40 + 32'(4 * w), 32'(w + 1));
        end
        drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 8'd4);
        cyc();
        idle();
        for (int b = 1; b <= 4; b++) begin
            if (b > 1) begin
                cyc();
            end
            check($sformatf("rdburst beat%0d valid", b), 32'(bus.read_data_valid), 32'd1);
            check($sformatf("rdburst beat%0d data", b), bus.read_data, 32'(b));
            check($sformatf("rdburst beat%0d ready", b), 32'(bus.request_ready), (b < 4) ? 32'd0 : 32'd1);
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 8'd0);
        cyc();
        idle();
        check("rdburst follow valid", 32'(bus.read_data_valid), 32'd1);
        check("rdburst follow data", bus.read_data, 32'h12BB_56DD);
        cyc();
        check("rdburst tail valid", 32'(bus.read_data_valid), 32'd0);

        // Write burst of 3 at the last word with a 2-cycle wait state, wrapping to word 0
        drive(1'b0, 1'b1, 32'h0000_0FFC, 32'hB0B0_0000, 4'hF, 1'b1, 8'd3);
        cyc();
        check("wrburst ready0", 32'(bus.request_ready), 32'd1);
        drive(1'b0, 1'b1, 32'h0000_0FFC, 32'hB1B1_1111, 4'hF, 1'b0, 8'd0);
        cyc();
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 8'd0);
        cyc();
        idle();
        check("wrburst wait read ignored", 32'(bus.read_data_valid), 32'd0);
        cyc();
        check("wrburst wait valid", 32'(bus.read_data_valid), 32'd0);
        drive(1'b0, 1'b1, 32'h0000_0000, 32'hB2B2_2222, 4'hF, 1'b0, 8'd0);
        cyc();
        idle();
        check("wrburst ready end", 32'(bus.request_ready), 32'd1);
        single_read("wrburst word1023", 32'h0000_0FFC, 32'hB0B0_0000);
        single_read("wrburst word0", 32'h0000_0000, 32'hB1B1_1111);
        single_read("wrburst word1", 32'h0000_0004, 32'hB2B2_2222);
        cyc();

        // Reset during beat 2 of an 8-beat read burst
        drive(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 8'd8);
        cyc();
        idle();
        check("rst burst beat1 data", bus.read_data, 32'd1);
        cyc();
        check("rst burst beat2 data", bus.read_data, 32'd2);
        #1 rest = 1'b0;
        #1;
        check("rst burst valid async", 32'(bus.read_data_valid), 32'd0);
        check("rst burst ready async", 32'(bus.request_ready), 32'd1);
        check("rst burst data cleared", bus.read_data, 32'h0);
        #2 rest = 1'b1;
        cyc();
        check("rst burst ready after", 32'(bus.request_ready), 32'd1);
        check("rst burst no beats", 32'(bus.read_data_valid), 32'd0);
        cyc();
        check("rst burst still idle", 32'(bus.read_data_valid), 32'd0);
        single_read("rst ram word 0x10", 32'h10, 32'h12BB_56DD);
        single_read("rst ram word 0x44", 32'h44, 32'd2);
        single_read("rst ram word 0x20", 32'h20, 32'hDEAD_BEEF);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
